// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared encodings, staff/note geometry and raster timing defaults
package score_pkg;

    typedef enum logic [1:0] {
        PT_NOTE  = 2'b00,
        PT_STAFF = 2'b01,
        PT_TEXT  = 2'b10,
        PT_BG    = 2'b11
    } pixel_type_t;

    typedef enum logic [1:0] {
        INSTR_VIOLIN   = 2'b00,
        INSTR_PIANO    = 2'b01,
        INSTR_ELECTRIC = 2'b10,
        INSTR_DEFAULT  = 2'b11
    } instr_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] pitch;
        instr_t     instr;
    } note_slot_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_TOTAL_DEF  = 800;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_TOTAL_DEF  = 525;
    localparam int COL_W_DEF    = 40;

    localparam int NUM_SLOTS = 16;

    // Note head: 8 px wide inside its column, 8 rows tall around a pitch-dependent centre
    localparam logic [9:0]  NOTE_X_LO    = 10'd16;
    localparam logic [9:0]  NOTE_X_HI    = 10'd23;
    localparam logic [10:0] NOTE_BASE_Y  = 11'd272;
    localparam logic [10:0] NOTE_HALF_UP = 11'd4;
    localparam logic [10:0] NOTE_HALF_DN = 11'd3;

    localparam logic [9:0] TEXT_Y_LO = 10'd16;
    localparam logic [9:0] TEXT_Y_HI = 10'd31;

    localparam logic [9:0] STAFF_ROW_0 = 10'd200;
    localparam logic [9:0] STAFF_ROW_1 = 10'd216;
    localparam logic [9:0] STAFF_ROW_2 = 10'd232;
    localparam logic [9:0] STAFF_ROW_3 = 10'd248;
    localparam logic [9:0] STAFF_ROW_4 = 10'd264;

    function automatic logic is_staff_row(input logic [9:0] y);
        return (y == STAFF_ROW_0) || (y == STAFF_ROW_1) || (y == STAFF_ROW_2) ||
               (y == STAFF_ROW_3) || (y == STAFF_ROW_4);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - pixel-enable driven h/v raster counters with blanking and frame wrap
module raster_counter #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixel_ce,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       blank,
    output logic       frame_wrap
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (pixel_ce) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    assign blank      = (h >= H_ACT) || (v >= V_ACT);
    // High on the enable cycle whose edge moves the raster to (0,0)
    assign frame_wrap = pixel_ce && (h == H_LAST) && (v == V_LAST);

endmodule

// File: rtl/pixel_type_gen.sv
// rtl/pixel_type_gen.sv - classifies each raster pixel as note/staff/text/background from a circular note buffer
module pixel_type_gen
    import score_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int COL_W    = COL_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixel_ce,
    input  logic       note_valid,
    output logic       note_ready,
    input  logic [3:0] note_pitch,
    input  logic [1:0] note_instr,
    output logic [9:0] x_out,
    output logic [9:0] y_out,
    output logic       active,
    output logic       frame_start,
    output logic [1:0] pixel_type,
    output logic [1:0] instrument_type
);

    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
    localparam logic [9:0] COLW  = 10'(COL_W);

    logic [9:0] h, v;
    logic       blank, frame_wrap;

    raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL)
    ) u_raster (
        .clk        (clk),
        .rst        (rst),
        .pixel_ce   (pixel_ce),
        .h          (h),
        .v          (v),
        .blank      (blank),
        .frame_wrap (frame_wrap)
    );

    note_slot_t slots [NUM_SLOTS];
    logic [3:0] wr_ptr, base;
    logic [4:0] count;
    logic       wr_en;
    logic [3:0] wr_ptr_nxt;
    logic [4:0] count_nxt;

    assign note_ready = (v >= V_ACT) && !rst;
    assign wr_en      = note_valid && note_ready;
    assign wr_ptr_nxt = wr_en ? wr_ptr + 4'd1 : wr_ptr;
    assign count_nxt  = (wr_en && count != 5'd16) ? count + 5'd1 : count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
            base   <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                slots[wr_ptr] <= '{valid: 1'b1, pitch: note_pitch, instr: instr_t'(note_instr)};
            end
            wr_ptr <= wr_ptr_nxt;
            count  <= count_nxt;
            // Once full, column 0 shows the oldest note, which is the slot about to be overwritten
            if (frame_wrap) begin
                base <= (count_nxt == 5'd16) ? wr_ptr_nxt : 4'd0;
            end
        end
    end

    logic [9:0]  col_full, x_in_col;
    logic [3:0]  slot_idx;
    note_slot_t  slot;
    logic [10:0] ctr, y_ext;
    logic        eligible, is_note, is_staff, is_text;
    pixel_type_t cls;

    always_comb begin
        col_full = h / COLW;
        x_in_col = h % COLW;
        slot_idx = base + col_full[3:0];
        slot     = slots[slot_idx];
        eligible = (col_full < {5'd0, count}) && slot.valid;
        ctr      = NOTE_BASE_Y - {4'd0, slot.pitch, 3'd0};
        y_ext    = {1'b0, v};
        is_note  = eligible && (x_in_col >= NOTE_X_LO) && (x_in_col <= NOTE_X_HI) &&
                   (y_ext + NOTE_HALF_UP >= ctr) && (y_ext <= ctr + NOTE_HALF_DN);
        is_staff = is_staff_row(v);
        is_text  = (v >= TEXT_Y_LO) && (v <= TEXT_Y_HI) && (h < {1'b0, count, 4'd0});
        cls      = PT_BG;
        if (is_note)       cls = PT_NOTE;
        else if (is_staff) cls = PT_STAFF;
        else if (is_text)  cls = PT_TEXT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_out           <= '0;
            y_out           <= '0;
            active          <= 1'b0;
            frame_start     <= 1'b0;
            pixel_type      <= PT_BG;
            instrument_type <= INSTR_DEFAULT;
        end else begin
            frame_start <= pixel_ce && (h == 10'd0) && (v == 10'd0);
            if (pixel_ce) begin
                x_out           <= h;
                y_out           <= v;
                active          <= !blank;
                pixel_type      <= blank ? PT_BG : cls;
                instrument_type <= (!blank && is_note) ? slot.instr : INSTR_DEFAULT;
            end
        end
    end

endmodule
